mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 31 +++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// simple_pkg: definitions shared by the memory port arbiter slice.
//   DEF_DATA_W / DEF_ADDR_W : default data and address widths
//   chan_tag_e              : owner of an in-flight read (none / fetch / data)
package simple_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 12;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_D    = 2'd2
   } chan_tag_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch channel, data channel and single memory port
// bundled together.
//   slave  : arbiter view (takes requests and m_q, drives grants/read data/memory bus)
//   master : environment view (requesters plus memory)
interface mem_port_arbiter_if
   import simple_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   // fetch channel
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // data channel
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // fetch-stage freeze
   logic              stall;
   // memory port
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_rw;
   logic [DATA_W-1:0] m_q;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_q,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             stall, m_addr, m_data, m_rw
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_q,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             stall, m_addr, m_data, m_rw
   );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep delay line recording which channel owns each
// read in flight. Shifts every cycle; reset empties every slot so reads in
// flight across a reset are forgotten.
//   clock, reset : clock, synchronous active-high reset
//   tag_in       : owner of the access issued this cycle (TAG_NONE for stores/idle)
//   tag_out      : owner of the read whose data is on m_q this cycle
module rd_tag_pipe
   import simple_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic      clock,
   input  logic      reset,
   input  chan_tag_e tag_in,
   output chan_tag_e tag_out
);

   chan_tag_e tag_q [RD_LAT];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign tag_out = tag_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between a fetch
// channel and a data channel. Data wins ties, except that after
// MAX_D_STREAK consecutive data grants with fetch waiting, fetch gets one
// slot (MAX_D_STREAK = 0 keeps strict data priority). Read data comes back
// RD_LAT cycles after issue and is steered to the owning channel.
//   clock, reset : clock, synchronous active-high reset
//   bus          : fetch/data request channels, stall, memory port (slave view)
module mem_port_arbiter
   import simple_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int RD_LAT       = 1,
   parameter int MAX_D_STREAK = 4
) (
   input  logic               clock,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   logic [SW-1:0]     streak_q;
   logic              force_if;
   logic              if_gnt;
   logic              d_gnt;
   logic              m_rw;
   logic [ADDR_W-1:0] m_addr;
   chan_tag_e         tag_in;
   chan_tag_e         tag_out;
   logic              if_rvalid;
   logic              d_rvalid;

   // Grants are gated by reset so nothing reaches memory while resetting.
   always_comb begin
      force_if = 1'b0;
      if (MAX_D_STREAK != 0)
         force_if = bus.if_req && bus.d_req && (streak_q == STREAK_MAX);
      d_gnt  = !reset && bus.d_req && !force_if;
      if_gnt = !reset && bus.if_req && !d_gnt;
   end

   always_comb begin
      m_addr = '0;
      if (if_gnt)     m_addr = bus.if_addr;
      else if (d_gnt) m_addr = bus.d_addr;
   end

   assign m_rw = d_gnt && bus.d_we;

   always_comb begin
      tag_in = TAG_NONE;
      if (if_gnt)                  tag_in = TAG_IF;
      else if (d_gnt && !bus.d_we) tag_in = TAG_D;
   end

   // Counts data grants that made fetch wait; saturates at the limit.
   always_ff @(posedge clock) begin
      if (reset)
         streak_q <= '0;
      else if (if_gnt || !bus.if_req)
         streak_q <= '0;
      else if (d_gnt && streak_q != STREAK_MAX)
         streak_q <= streak_q + 1'b1;
   end

   rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clock   (clock),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // The pipe still holds pre-reset tags during the first reset cycle.
   assign if_rvalid = !reset && (tag_out == TAG_IF);
   assign d_rvalid  = !reset && (tag_out == TAG_D);

   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.stall     = bus.if_req && !if_gnt;
   assign bus.m_addr    = m_addr;
   assign bus.m_rw      = m_rw;
   assign bus.m_data    = m_rw ? bus.d_wdata : '0;
   assign bus.if_rvalid = if_rvalid;
   assign bus.if_rdata  = if_rvalid ? bus.m_q : '0;
   assign bus.d_rvalid  = d_rvalid;
   assign bus.d_rdata   = d_rvalid ? bus.m_q : '0;

endmodule
